// File: rtl/vending_machine_multi_pkg.sv
// Shared definitions for the multi-product vending controller: coin
// encodings, the controller state type and the coin-to-rupee helper.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  // Face value in Rs of a coin encoding; the "no coin" code is worth 0.
  function automatic logic [4:0] coin_value(input logic [1:0] coin);
    logic [4:0] v;
    case (coin)
      COIN_5:  v = 5'd5;
      COIN_10: v = 5'd10;
      COIN_20: v = 5'd20;
      default: v = 5'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vending_machine_multi_if.sv
// Front-end / back-end signal bundle of the vending controller.
// Strobe semantics: sel_valid, cancel and restock are single-cycle strobes
// sampled on the clock edge; coin_in is sampled every cycle. dispense,
// change_valid, coin_reject and sel_error are single-cycle valid pulses with
// no back-pressure; dispense_id and change_coin are meaningful only while
// their valid is high and are driven to zero otherwise.
interface vending_machine_multi_if #(
  parameter int NUM_PRODUCTS = 4,
  parameter int CREDIT_W     = 8
);
  import vend_pkg::*;

  localparam int SEL_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1;

  logic [1:0]              coin_in;
  logic                    sel_valid;
  logic [SEL_W-1:0]        sel_id;
  logic                    cancel;
  logic                    restock;
  logic                    dispense;
  logic [SEL_W-1:0]        dispense_id;
  logic                    change_valid;
  logic [1:0]              change_coin;
  logic                    coin_reject;
  logic                    sel_error;
  logic [CREDIT_W-1:0]     credit;
  logic [NUM_PRODUCTS-1:0] sold_out;
  logic                    busy;
  state_t                  state;    // debug view of the controller FSM

  modport master (
    output coin_in, sel_valid, sel_id, cancel, restock,
    input  dispense, dispense_id, change_valid, change_coin, coin_reject,
           sel_error, credit, sold_out, busy, state
  );

  modport slave (
    input  coin_in, sel_valid, sel_id, cancel, restock,
    output dispense, dispense_id, change_valid, change_coin, coin_reject,
           sel_error, credit, sold_out, busy, state
  );

endinterface

// File: rtl/vending_machine_multi_change_dispenser.sv
// Greedy change selector: picks the largest coin not exceeding the credit,
// registers it onto the change outputs and hands back the reduced credit.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                active,
  input  logic [CREDIT_W-1:0] credit,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic [CREDIT_W-1:0] credit_next
);

  logic [1:0] coin_sel;

  // Largest-first coin choice; credit is a multiple of 5 so 5Rs is the floor.
  always_comb begin
    coin_sel = COIN_5;
    if (credit >= CREDIT_W'(20))      coin_sel = COIN_20;
    else if (credit >= CREDIT_W'(10)) coin_sel = COIN_10;
    credit_next = credit - CREDIT_W'(coin_value(coin_sel));
  end

  // One registered coin per active cycle; outputs are zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_valid <= 1'b0;
      change_coin  <= COIN_NONE;
    end else begin
      change_valid <= active;
      change_coin  <= active ? coin_sel : COIN_NONE;
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: coin credit, product selection against
// per-product stock and price, and greedy serial change/refund.
module vending_machine_multi
  import vend_pkg::*;
#(
  parameter int                          NUM_PRODUCTS = 4,
  parameter int                          CREDIT_W     = 8,
  parameter int                          MAX_CREDIT   = 100,
  parameter logic [8*NUM_PRODUCTS-1:0]   PRICES       = {8'd10, 8'd25, 8'd20, 8'd15},
  parameter int                          STOCK_W      = 4,
  parameter int                          STOCK_INIT   = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  vending_machine_multi_if.slave bus
);

  localparam int SEL_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1;

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit, credit_n;
  logic                dispense, dispense_n;
  logic [SEL_W-1:0]    dispense_id, dispense_id_n;
  logic                coin_reject, coin_reject_n;
  logic                sel_error, sel_error_n;
  logic                vend_accept;
  logic                restock_apply;

  logic [7:0]          price_arr [NUM_PRODUCTS];
  logic [STOCK_W-1:0]  stock     [NUM_PRODUCTS];
  logic [NUM_PRODUCTS-1:0] empty_vec;

  logic                coin_present;
  logic [CREDIT_W:0]   credit_sum;
  logic [CREDIT_W:0]   price_ext;
  logic [7:0]          price_sel;
  logic                sel_in_range;
  logic                sel_ok;
  logic                chg_active;
  logic [CREDIT_W-1:0] chg_credit_next;

  // Per-product price table and stock counters.
  for (genvar i = 0; i < NUM_PRODUCTS; i++) begin : g_prod
    assign price_arr[i] = PRICES[8*i +: 8];
    assign empty_vec[i] = (stock[i] == '0);

    // Stock reloads on restock and counts down on each accepted vend.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        stock[i] <= STOCK_W'(STOCK_INIT);
      else if (restock_apply)
        stock[i] <= STOCK_W'(STOCK_INIT);
      else if (vend_accept && (bus.sel_id == SEL_W'(i)))
        stock[i] <= stock[i] - STOCK_W'(1);
    end
  end

  assign coin_present = (bus.coin_in != COIN_NONE);
  assign credit_sum   = {1'b0, credit} + (CREDIT_W+1)'(coin_value(bus.coin_in));
  assign sel_in_range = (32'(bus.sel_id) < NUM_PRODUCTS);
  assign price_sel    = sel_in_range ? price_arr[bus.sel_id] : 8'd0;
  assign price_ext    = (CREDIT_W+1)'(price_sel);
  assign sel_ok       = sel_in_range && (stock[bus.sel_id] != '0) &&
                        ({1'b0, credit} >= price_ext);
  assign chg_active   = (state == S_CHANGE) && (credit != '0);

  vend_change_dispenser #(.CREDIT_W(CREDIT_W)) u_change (
    .clk          (clk),
    .rst_n        (rst_n),
    .active       (chg_active),
    .credit       (credit),
    .change_valid (bus.change_valid),
    .change_coin  (bus.change_coin),
    .credit_next  (chg_credit_next)
  );

  // Controller state and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      credit      <= '0;
      dispense    <= 1'b0;
      dispense_id <= '0;
      coin_reject <= 1'b0;
      sel_error   <= 1'b0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      dispense    <= dispense_n;
      dispense_id <= dispense_id_n;
      coin_reject <= coin_reject_n;
      sel_error   <= sel_error_n;
    end
  end

  // Next state: cancel beats selection beats coin in IDLE/CREDIT; VEND and
  // CHANGE ignore requests and bounce any coin back.
  always_comb begin
    state_n       = state;
    credit_n      = credit;
    dispense_n    = 1'b0;
    dispense_id_n = '0;
    coin_reject_n = 1'b0;
    sel_error_n   = 1'b0;
    vend_accept   = 1'b0;
    restock_apply = (state == S_IDLE) && bus.restock && !bus.sel_valid && !bus.cancel;
    case (state)
      S_IDLE, S_CREDIT: begin
        if (bus.cancel) begin
          coin_reject_n = coin_present;
          if (credit != '0) state_n = S_CHANGE;
        end else if (bus.sel_valid) begin
          coin_reject_n = coin_present;
          if (sel_ok) begin
            vend_accept   = 1'b1;
            credit_n      = credit - CREDIT_W'(price_sel);
            dispense_n    = 1'b1;
            dispense_id_n = bus.sel_id;
            state_n       = S_VEND;
          end else begin
            sel_error_n = 1'b1;
          end
        end else if (coin_present) begin
          if (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
            credit_n = credit_sum[CREDIT_W-1:0];
            state_n  = S_CREDIT;
          end else begin
            coin_reject_n = 1'b1;
          end
        end
      end
      S_VEND: begin
        coin_reject_n = coin_present;
        state_n       = (credit != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        coin_reject_n = coin_present;
        if (credit != '0) credit_n = chg_credit_next;
        else              state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.dispense    = dispense;
  assign bus.dispense_id = dispense_id;
  assign bus.coin_reject = coin_reject;
  assign bus.sel_error   = sel_error;
  assign bus.credit      = credit;
  assign bus.sold_out    = empty_vec;
  assign bus.busy        = (state == S_VEND) || (state == S_CHANGE);
  assign bus.state       = state;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed coin/select/cancel/restock
// sequences; expected output events (tagged with the cycle they must appear
// in) go into a sorted queue that a negedge monitor drains.
module tb_vending_machine_multi;
  import vend_pkg::*;

  localparam int NP = 4;
  localparam int CW = 8;
  localparam int EW = 36;   // {cycle[31:0], kind[1:0], data[1:0]}

  localparam logic [1:0] K_DISP = 2'd0;
  localparam logic [1:0] K_CHG  = 2'd1;
  localparam logic [1:0] K_REJ  = 2'd2;
  localparam logic [1:0] K_SERR = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vending_machine_multi_if #(.NUM_PRODUCTS(NP), .CREDIT_W(CW)) bus ();

  vending_machine_multi #(
    .NUM_PRODUCTS (NP),
    .CREDIT_W     (CW),
    .MAX_CREDIT   (100),
    .PRICES       ({8'd10, 8'd25, 8'd20, 8'd15}),
    .STOCK_W      (4),
    .STOCK_INIT   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int lat, input logic [1:0] kind, input logic [1:0] data);
    logic [EW-1:0] e;
    e = {32'(cyc + lat), kind, data};
    exp_q.push_back(e);
    exp_q.sort();
  endtask

  task automatic observe(input logic [1:0] kind, input logic [1:0] data);
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    got = {32'(cyc), kind, data};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data %0d at cycle %0d, queue empty",
               kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e !== got) begin
        n_fail++;
        $display("FAIL event: got kind %0d data %0d at cycle %0d expected kind %0d data %0d at cycle %0d",
                 kind, data, cyc, e[3:2], e[1:0], e[35:4]);
      end
    end
  endtask

  // Monitor: flag overdue expectations, then match each event seen this cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0][35:4] < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_event: expected kind %0d data %0d at cycle %0d, not seen by cycle %0d",
                 exp_q[0][3:2], exp_q[0][1:0], exp_q[0][35:4], cyc);
        exp_q.delete(0);
      end
      if (bus.dispense)     observe(K_DISP, bus.dispense_id);
      if (bus.change_valid) observe(K_CHG, bus.change_coin);
      if (bus.coin_reject)  observe(K_REJ, 2'd0);
      if (bus.sel_error)    observe(K_SERR, 2'd0);
    end
  end

  task automatic drive(input logic [1:0] coin, input logic sv, input logic [1:0] sid,
                       input logic can, input logic rs);
    bus.coin_in   = coin;
    bus.sel_valid = sv;
    bus.sel_id    = sid;
    bus.cancel    = can;
    bus.restock   = rs;
    @(negedge clk);
    bus.coin_in   = COIN_NONE;
    bus.sel_valid = 1'b0;
    bus.sel_id    = 2'd0;
    bus.cancel    = 1'b0;
    bus.restock   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(COIN_NONE, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic check_idle(input string name);
    check({name, "_state"}, 32'(bus.state), 32'(S_IDLE));
    check({name, "_credit"}, 32'(bus.credit), 32'd0);
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  // Watchdog: the directed run is short, so a stall here means a hang.
  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  // Directed stimulus.
  initial begin
    bus.coin_in   = COIN_NONE;
    bus.sel_valid = 1'b0;
    bus.sel_id    = 2'd0;
    bus.cancel    = 1'b0;
    bus.restock   = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(bus.state), 32'(S_IDLE));
    check("rst_credit", 32'(bus.credit), 32'd0);
    check("rst_sold_out", 32'(bus.sold_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pulses", 32'({bus.dispense, bus.change_valid, bus.coin_reject, bus.sel_error}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 5 + 10, buy product 0 (15) exactly, no change.
    drive(COIN_5, 1'b0, 2'd0, 1'b0, 1'b0);
    drive(COIN_10, 1'b0, 2'd0, 1'b0, 1'b0);
    check("t1_credit", 32'(bus.credit), 32'd15);
    check("t1_state_credit", 32'(bus.state), 32'(S_CREDIT));
    expect_ev(1, K_DISP, 2'd0);
    drive(COIN_NONE, 1'b1, 2'd0, 1'b0, 1'b0);
    check("t1_vend_state", 32'(bus.state), 32'(S_VEND));
    check("t1_vend_busy", 32'(bus.busy), 32'd1);
    check("t1_vend_credit", 32'(bus.credit), 32'd0);
    idle(1);
    check_idle("t1_end");
    check("t1_busy_end", 32'(bus.busy), 32'd0);

    // 2: 20, buy product 0, one 5Rs change coin.
    drive(COIN_20, 1'b0, 2'd0, 1'b0, 1'b0);
    check("t2_credit", 32'(bus.credit), 32'd20);
    expect_ev(1, K_DISP, 2'd0);
    expect_ev(3, K_CHG, COIN_5);
    drive(COIN_NONE, 1'b1, 2'd0, 1'b0, 1'b0);
    check("t2_vend_credit", 32'(bus.credit), 32'd5);
    idle(1);
    check("t2_change_state", 32'(bus.state), 32'(S_CHANGE));
    idle(1);
    check("t2_change_credit", 32'(bus.credit), 32'd0);
    idle(1);
    check_idle("t2_end");
    check("t2_sold_out", 32'(bus.sold_out), 32'b0001);

    // 3: credit 50, cancel -> 20, 20, 10.
    drive(COIN_20, 1'b0, 2'd0, 1'b0, 1'b0);
    drive(COIN_20, 1'b0, 2'd0, 1'b0, 1'b0);
    drive(COIN_10, 1'b0, 2'd0, 1'b0, 1'b0);
    check("t3_credit", 32'(bus.credit), 32'd50);
    expect_ev(2, K_CHG, COIN_20);
    expect_ev(3, K_CHG, COIN_20);
    expect_ev(4, K_CHG, COIN_10);
    drive(COIN_NONE, 1'b0, 2'd0, 1'b1, 1'b0);
    idle(1);
    check("t3_busy", 32'(bus.busy), 32'd1);
    idle(3);
    check_idle("t3_end");

    // 4: underfunded selection with a coin in the same cycle, then sold-out selection.
    drive(COIN_10, 1'b0, 2'd0, 1'b0, 1'b0);
    expect_ev(1, K_REJ, 2'd0);
    expect_ev(1, K_SERR, 2'd0);
    drive(COIN_20, 1'b1, 2'd2, 1'b0, 1'b0);
    check("t4_credit_kept", 32'(bus.credit), 32'd10);
    check("t4_state", 32'(bus.state), 32'(S_CREDIT));
    drive(COIN_10, 1'b0, 2'd0, 1'b0, 1'b0);
    expect_ev(1, K_SERR, 2'd0);
    drive(COIN_NONE, 1'b1, 2'd0, 1'b0, 1'b0);
    check("t4_soldout_credit", 32'(bus.credit), 32'd20);
    expect_ev(2, K_CHG, COIN_20);
    drive(COIN_NONE, 1'b0, 2'd0, 1'b1, 1'b0);
    idle(3);
    check_idle("t4_end");

    // 5: exhaust product 3, refused third buy, restock only honoured in IDLE.
    for (int k = 0; k < 2; k++) begin
      drive(COIN_10, 1'b0, 2'd0, 1'b0, 1'b0);
      expect_ev(1, K_DISP, 2'd3);
      drive(COIN_NONE, 1'b1, 2'd3, 1'b0, 1'b0);
      idle(1);
    end
    check("t5_sold_out", 32'(bus.sold_out), 32'b1001);
    drive(COIN_10, 1'b0, 2'd0, 1'b0, 1'b0);
    expect_ev(1, K_SERR, 2'd0);
    drive(COIN_NONE, 1'b1, 2'd3, 1'b0, 1'b0);
    check("t5_credit_kept", 32'(bus.credit), 32'd10);
    drive(COIN_NONE, 1'b0, 2'd0, 1'b0, 1'b1);
    check("t5_restock_ignored", 32'(bus.sold_out), 32'b1001);
    expect_ev(2, K_CHG, COIN_10);
    drive(COIN_NONE, 1'b0, 2'd0, 1'b1, 1'b0);
    idle(3);
    check_idle("t5_refund");
    drive(COIN_NONE, 1'b0, 2'd0, 1'b0, 1'b1);
    check("t5_restocked", 32'(bus.sold_out), 32'd0);

    // Cancel with no credit is a no-op, but the coin beside it bounces.
    expect_ev(1, K_REJ, 2'd0);
    drive(COIN_10, 1'b0, 2'd0, 1'b1, 1'b0);
    check_idle("t6_cancel_zero");

    // 6: fill to the ceiling, overflow coin, reset in the middle of change.
    repeat (5) drive(COIN_20, 1'b0, 2'd0, 1'b0, 1'b0);
    check("t6_credit_max", 32'(bus.credit), 32'd100);
    expect_ev(1, K_REJ, 2'd0);
    drive(COIN_5, 1'b0, 2'd0, 1'b0, 1'b0);
    check("t6_overflow_credit", 32'(bus.credit), 32'd100);
    check("t6_overflow_state", 32'(bus.state), 32'(S_CREDIT));
    for (int k = 2; k <= 6; k++) expect_ev(k, K_CHG, COIN_20);
    drive(COIN_NONE, 1'b0, 2'd0, 1'b1, 1'b0);
    idle(1);
    expect_ev(1, K_REJ, 2'd0);
    drive(COIN_5, 1'b0, 2'd0, 1'b0, 1'b0);
    check("t6_second_coin", 32'(bus.change_valid), 32'd1);
    check("t6_mid_credit", 32'(bus.credit), 32'd60);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_pulses", 32'({bus.dispense, bus.change_valid, bus.coin_reject, bus.sel_error}), 32'd0);
    check("t6_rst_coin", 32'(bus.change_coin), 32'd0);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check_idle("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check("t6_quiet_after_rst", 32'(bus.change_valid), 32'd0);
    check_idle("t6_end");
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    summary();
    $finish;
  end

endmodule
